// File: rtl/tilelink_error_slave.sv
`default_nettype none
// ============================================================================
// Module   : tilelink_error_slave
// Brief    : Default TileLink target that drains unmapped A requests and
//            answers each one with a correctly shaped, denied D response.
// Revision : 1.0 - initial release
// ============================================================================
module tilelink_error_slave #(
    parameter int TL_RS       = 5,
    parameter int TL_AW       = 32,
    parameter int TL_DW       = 32,
    parameter int TL_SZ       = 4,
    parameter int TL_MAX_SIZE = 6
) (
    input  logic                  tilelink_clock_i,
    input  logic                  tilelink_reset_i,
    input  logic [2:0]            a_opcode,
    input  logic [2:0]            a_param,
    input  logic [TL_SZ-1:0]      a_size,
    input  logic [TL_RS-1:0]      a_source,
    input  logic [TL_AW-1:0]      a_address,
    input  logic [TL_DW/8-1:0]    a_mask,
    input  logic [TL_DW-1:0]      a_data,
    input  logic                  a_corrupt,
    input  logic                  a_valid,
    output logic                  a_ready,
    output logic [2:0]            d_opcode,
    output logic [1:0]            d_param,
    output logic [TL_SZ-1:0]      d_size,
    output logic [TL_RS-1:0]      d_source,
    output logic                  d_denied,
    output logic [TL_DW-1:0]      d_data,
    output logic                  d_corrupt,
    output logic                  d_valid,
    input  logic                  d_ready
);

    localparam int                 c_B      = $clog2(TL_DW / 8);
    localparam int                 c_CW     = TL_MAX_SIZE - c_B + 1;
    localparam logic [TL_SZ-1:0]   c_MAX_SZ = TL_SZ'(TL_MAX_SIZE);
    localparam logic [TL_SZ-1:0]   c_B_SZ   = TL_SZ'(c_B);
    localparam logic [c_CW-1:0]    c_ONE    = c_CW'(1);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_DRAIN = 2'd1;
    localparam logic [1:0] c_RESP  = 2'd2;

    logic [1:0]       r_state;
    logic [c_CW-1:0]  r_a_cnt;
    logic [c_CW-1:0]  r_d_cnt;
    logic [c_CW-1:0]  r_resp_beats;

    logic [TL_SZ-1:0] w_s;
    logic [TL_SZ-1:0] w_shift;
    logic [c_CW-1:0]  w_beats;
    logic [c_CW-1:0]  w_resp_beats;
    logic [2:0]       w_resp_op;
    logic             w_needs_drain;
    logic             w_unused;

    // Payload fields the error target never inspects.
    assign w_unused = ^{a_param, a_address, a_mask, a_data, a_corrupt};

    assign d_param = 2'b00;
    assign d_data  = '0;

    // Beat count uses the clamped size; the echoed size stays unclamped.
    assign w_s     = (a_size > c_MAX_SZ) ? c_MAX_SZ : a_size;
    assign w_shift = w_s - c_B_SZ;
    assign w_beats = (w_s > c_B_SZ) ? (c_ONE << w_shift) : c_ONE;

    always_comb begin
        w_resp_op    = 3'd0;
        w_resp_beats = c_ONE;
        case (a_opcode)
            3'd2, 3'd3, 3'd4: begin
                w_resp_op    = 3'd1;
                w_resp_beats = w_beats;
            end
            3'd5:    w_resp_op = 3'd2;
            default: w_resp_op = 3'd0;
        endcase
    end

    assign w_needs_drain = !a_opcode[2] && (w_beats != c_ONE);

    always_ff @(posedge tilelink_clock_i) begin
        if (tilelink_reset_i) begin
            r_state      <= c_IDLE;
            r_a_cnt      <= '0;
            r_d_cnt      <= '0;
            r_resp_beats <= '0;
            a_ready      <= 1'b1;
            d_valid      <= 1'b0;
            d_opcode     <= 3'd0;
            d_size       <= '0;
            d_source     <= '0;
            d_denied     <= 1'b0;
            d_corrupt    <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (a_valid) begin
                        d_opcode     <= w_resp_op;
                        d_size       <= a_size;
                        d_source     <= a_source;
                        d_denied     <= 1'b1;
                        d_corrupt    <= (w_resp_op == 3'd1);
                        r_resp_beats <= w_resp_beats;
                        if (w_needs_drain) begin
                            r_a_cnt <= w_beats - c_ONE;
                            r_state <= c_DRAIN;
                        end else begin
                            r_d_cnt <= w_resp_beats;
                            a_ready <= 1'b0;
                            d_valid <= 1'b1;
                            r_state <= c_RESP;
                        end
                    end
                end
                c_DRAIN: begin
                    if (a_valid) begin
                        r_a_cnt <= r_a_cnt - c_ONE;
                        if (r_a_cnt == c_ONE) begin
                            r_d_cnt <= r_resp_beats;
                            a_ready <= 1'b0;
                            d_valid <= 1'b1;
                            r_state <= c_RESP;
                        end
                    end
                end
                c_RESP: begin
                    if (d_ready) begin
                        r_d_cnt <= r_d_cnt - c_ONE;
                        if (r_d_cnt == c_ONE) begin
                            a_ready <= 1'b1;
                            d_valid <= 1'b0;
                            r_state <= c_IDLE;
                        end
                    end
                end
                default: begin
                    a_ready <= 1'b1;
                    d_valid <= 1'b0;
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
